lane_vrf_write_sink: RTL and testbench

Receiving end of a lane's VRF write-request channel. Accepts {vd, offset, mask, data, last, instructionIndex} over ready/valid and commits each request into a 1R1W, 32-bit-word SRAM macro that has no byte enables. Partial-mask writes therefore go through a pipelined read-modify-write. The block also tracks per-instruction in-flight writes and signals each instruction's final commit.

---
 rtl/lane_vrf_pkg.sv | 28 ++
 rtl/vrf_byte_merge.sv | 20 ++
 rtl/lane_vrf_write_sink.sv | 160 ++++++++++++++++
 tb/tb_lane_vrf_write_sink.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lane_vrf_pkg.sv
// Shared widths, request payload and address helper for the lane VRF write sink.
package lane_vrf_pkg;

  localparam int LANE_DATA_W   = 32;
  localparam int LANE_VD_W     = 5;
  localparam int LANE_OFFSET_W = 5;
  localparam int LANE_IDX_W    = 3;
  localparam int BYTE_W        = 8;
  localparam int LANE_MASK_W   = LANE_DATA_W / BYTE_W;
  localparam int LANE_ADDR_W   = LANE_VD_W + LANE_OFFSET_W;

  typedef struct packed {
    logic [LANE_VD_W-1:0]     vd;
    logic [LANE_OFFSET_W-1:0] offset;
    logic [LANE_MASK_W-1:0]   mask;
    logic [LANE_DATA_W-1:0]   data;
    logic                     last;
    logic [LANE_IDX_W-1:0]    instructionIndex;
  } vrf_write_req_t;

  function automatic logic [LANE_ADDR_W-1:0] vrf_addr(
    input logic [LANE_VD_W-1:0]     vd,
    input logic [LANE_OFFSET_W-1:0] offset
  );
    return {vd, offset};
  endfunction

endpackage

// File: rtl/vrf_byte_merge.sv
// Per-byte select between new write data and the old SRAM word; purely combinational.
module vrf_byte_merge
  import lane_vrf_pkg::*;
#(
  parameter int DATA_W = LANE_DATA_W
) (
  input  logic [DATA_W-1:0]        i_new,
  input  logic [DATA_W-1:0]        i_old,
  input  logic [DATA_W/BYTE_W-1:0] i_mask,
  output logic [DATA_W-1:0]        o_merged
);

  always_comb begin
    o_merged = i_old;
    for (int k = 0; k < DATA_W / BYTE_W; k++) begin
      if (i_mask[k]) o_merged[k*BYTE_W +: BYTE_W] = i_new[k*BYTE_W +: BYTE_W];
    end
  end

endmodule

// File: rtl/lane_vrf_write_sink.sv
// VRF write sink: 2-stage read-modify-write into a no-byte-enable SRAM, write at accept+2, ready drops on an R/W address hazard.
// VRF_WRITE_FORWARD_EN forwards W's merged word to the following same-row write instead of stalling R for one cycle.
module lane_vrf_write_sink
  import lane_vrf_pkg::*;
#(
  parameter int DATA_W   = LANE_DATA_W,
  parameter int VD_W     = LANE_VD_W,
  parameter int OFFSET_W = LANE_OFFSET_W,
  parameter int IDX_W    = LANE_IDX_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       vrfWriteRequest_valid,
  output logic                       vrfWriteRequest_ready,
  input  logic [VD_W-1:0]            vrfWriteRequest_bits_vd,
  input  logic [OFFSET_W-1:0]        vrfWriteRequest_bits_offset,
  input  logic [DATA_W/8-1:0]        vrfWriteRequest_bits_mask,
  input  logic [DATA_W-1:0]          vrfWriteRequest_bits_data,
  input  logic                       vrfWriteRequest_bits_last,
  input  logic [IDX_W-1:0]           vrfWriteRequest_bits_instructionIndex,
  output logic                       rf_ren,
  output logic [VD_W+OFFSET_W-1:0]   rf_raddr,
  input  logic [DATA_W-1:0]          rf_rdata,
  output logic                       rf_wen,
  output logic [VD_W+OFFSET_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]          rf_wdata,
  output logic [(1<<IDX_W)-1:0]      inflight,
  output logic                       lastCommit_valid,
  output logic [IDX_W-1:0]           lastCommit_index
);

  localparam int NIDX   = 1 << IDX_W;
  localparam int ADDR_W = VD_W + OFFSET_W;

  // The payload struct is sized by the package widths; instance parameters must match them.
  vrf_write_req_t w_in;
  vrf_write_req_t r_rd;
  vrf_write_req_t r_wr;
  logic           r_rd_vld;
  logic           r_wr_vld;

  logic              w_rd_partial;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_wr_wen;
  logic              w_hazard;
  logic              w_rd_adv;
  logic              w_ren;
  logic              w_acc;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;
  logic [NIDX-1:0]   w_inc;
  logic [NIDX-1:0]   w_dec;
  logic [1:0]        r_cnt [NIDX];

  always_comb begin
    w_in                  = '0;
    w_in.vd               = vrfWriteRequest_bits_vd;
    w_in.offset           = vrfWriteRequest_bits_offset;
    w_in.mask             = vrfWriteRequest_bits_mask;
    w_in.data             = vrfWriteRequest_bits_data;
    w_in.last             = vrfWriteRequest_bits_last;
    w_in.instructionIndex = vrfWriteRequest_bits_instructionIndex;
  end

  assign w_rd_partial = r_rd_vld && (r_rd.mask != '1) && (r_rd.mask != '0);
  assign w_rd_addr    = vrf_addr(r_rd.vd, r_rd.offset);
  assign w_wr_addr    = vrf_addr(r_wr.vd, r_wr.offset);
  assign w_wr_wen     = r_wr_vld && (r_wr.mask != '0);
  // A read issued in the same cycle as W's write would return the pre-write word.
  assign w_hazard     = w_rd_partial && w_wr_wen && (w_rd_addr == w_wr_addr);

`ifdef VRF_WRITE_FORWARD_EN
  logic [DATA_W-1:0] r_fwd;
  logic              r_fwd_vld;

  assign w_rd_adv = r_rd_vld;
  assign w_ren    = w_rd_partial;
  assign w_old    = r_fwd_vld ? r_fwd : rf_rdata;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_fwd_vld <= 1'b0;
      r_fwd     <= '0;
    end else begin
      r_fwd_vld <= w_hazard;
      if (w_hazard) r_fwd <= w_merged;
    end
  end
`else
  assign w_rd_adv = r_rd_vld && !w_hazard;
  assign w_ren    = w_rd_partial && !w_hazard;
  assign w_old    = rf_rdata;
`endif

  assign vrfWriteRequest_ready = !r_rd_vld || w_rd_adv;
  assign w_acc                 = vrfWriteRequest_valid && vrfWriteRequest_ready;

  vrf_byte_merge #(
    .DATA_W (DATA_W)
  ) u_merge (
    .i_new    (r_wr.data),
    .i_old    (w_old),
    .i_mask   (r_wr.mask),
    .o_merged (w_merged)
  );

  // Outputs are held quiet while reset is low so a dropped W entry never reaches the SRAM.
  assign rf_ren           = reset_n && w_ren;
  assign rf_raddr         = rf_ren ? w_rd_addr : '0;
  assign rf_wen           = reset_n && w_wr_wen;
  assign rf_waddr         = rf_wen ? w_wr_addr : '0;
  assign rf_wdata         = rf_wen ? w_merged : '0;
  assign lastCommit_valid = reset_n && r_wr_vld && r_wr.last;
  assign lastCommit_index = lastCommit_valid ? r_wr.instructionIndex : '0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_rd_vld <= 1'b0;
      r_wr_vld <= 1'b0;
      r_rd     <= '0;
      r_wr     <= '0;
    end else begin
      if (w_acc) begin
        r_rd     <= w_in;
        r_rd_vld <= 1'b1;
      end else if (w_rd_adv) begin
        r_rd_vld <= 1'b0;
      end
      r_wr_vld <= w_rd_adv;
      if (w_rd_adv) r_wr <= r_rd;
    end
  end

  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < NIDX; i++) begin
      w_inc[i] = w_acc && (w_in.instructionIndex == IDX_W'(i));
      w_dec[i] = r_wr_vld && (r_wr.instructionIndex == IDX_W'(i));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NIDX; i++) r_cnt[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NIDX; i++) begin
        if (w_inc[i] && !w_dec[i])      r_cnt[i] <= r_cnt[i] + 2'd1;
        else if (!w_inc[i] && w_dec[i]) r_cnt[i] <= r_cnt[i] - 2'd1;
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NIDX; i++) inflight[i] = (r_cnt[i] != 2'd0);
  end

endmodule

// File: tb/tb_lane_vrf_write_sink.sv
// Bench for lane_vrf_write_sink: SRAM model, write/last-commit scoreboard, per-scenario timing checks.
module tb_lane_vrf_write_sink;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_vd;
  logic [4:0]  req_offset;
  logic [3:0]  req_mask;
  logic [31:0] req_data;
  logic        req_last;
  logic [2:0]  req_idx;
  logic        rf_ren;
  logic [9:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rf_wen;
  logic [9:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [7:0]  inflight;
  logic        lc_valid;
  logic [2:0]  lc_index;

  always #5 clock = ~clock;

  lane_vrf_write_sink dut (
    .clock                                 (clock),
    .reset_n                               (reset_n),
    .vrfWriteRequest_valid                 (req_valid),
    .vrfWriteRequest_ready                 (req_ready),
    .vrfWriteRequest_bits_vd               (req_vd),
    .vrfWriteRequest_bits_offset           (req_offset),
    .vrfWriteRequest_bits_mask             (req_mask),
    .vrfWriteRequest_bits_data             (req_data),
    .vrfWriteRequest_bits_last             (req_last),
    .vrfWriteRequest_bits_instructionIndex (req_idx),
    .rf_ren                                (rf_ren),
    .rf_raddr                              (rf_raddr),
    .rf_rdata                              (rf_rdata),
    .rf_wen                                (rf_wen),
    .rf_waddr                              (rf_waddr),
    .rf_wdata                              (rf_wdata),
    .inflight                              (inflight),
    .lastCommit_valid                      (lc_valid),
    .lastCommit_index                      (lc_index)
  );

  // 1R1W SRAM: read data one cycle after ren, same-cycle read of a written row returns old data.
  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];
  logic [31:0] rdata_q;
  assign rf_rdata = rdata_q;

  always @(posedge clock) begin
    if (rf_ren === 1'b1) rdata_q <= mem[rf_raddr];
    if (rf_wen === 1'b1) mem[rf_waddr] <= rf_wdata;
  end

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr_q[$];
  logic [2:0] exp_last_q[$];
  int         errors = 0;
  int         checks = 0;
  bit         mon_en = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      if (rf_wen === 1'b1) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_write: addr=%h data=%h, required no write", rf_waddr, rf_wdata);
        end else begin
          wr_t e;
          e = exp_wr_q.pop_front();
          if (rf_waddr !== e.addr || rf_wdata !== e.data) begin
            errors++;
            $display("FAIL sb_write: got addr=%h data=%h, required addr=%h data=%h",
                     rf_waddr, rf_wdata, e.addr, e.data);
          end
        end
      end
      if (lc_valid === 1'b1) begin
        checks++;
        if (exp_last_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_last: index=%0d, required no pulse", lc_index);
        end else begin
          logic [2:0] ei;
          ei = exp_last_q.pop_front();
          if (lc_index !== ei) begin
            errors++;
            $display("FAIL sb_last_index: got %0d, required %0d", lc_index, ei);
          end
        end
      end
    end
  end

  task automatic push_expect(input logic [4:0] vd, input logic [4:0] off, input logic [3:0] mask,
                             input logic [31:0] data, input logic last, input logic [2:0] idx);
    logic [9:0]  a;
    logic [31:0] m;
    a = {vd, off};
    if (mask != 4'h0) begin
      m = shadow[a];
      for (int k = 0; k < 4; k++) if (mask[k]) m[8*k +: 8] = data[8*k +: 8];
      shadow[a] = m;
      exp_wr_q.push_back('{a, m});
    end
    if (last) exp_last_q.push_back(idx);
  endtask

  task automatic set_req(input logic [4:0] vd, input logic [4:0] off, input logic [3:0] mask,
                         input logic [31:0] data, input logic last, input logic [2:0] idx);
    req_vd = vd; req_offset = off; req_mask = mask;
    req_data = data; req_last = last; req_idx = idx;
    req_valid = 1'b1;
  endtask

  // Starts and ends just after a rising edge; returns in the cycle after acceptance.
  task automatic send_one(input logic [4:0] vd, input logic [4:0] off, input logic [3:0] mask,
                          input logic [31:0] data, input logic last, input logic [2:0] idx,
                          input bit track);
    bit accepted = 1'b0;
    set_req(vd, off, mask, data, last, idx);
    for (int n = 0; n < 10 && !accepted; n++) begin
      @(negedge clock);
      if (req_ready === 1'b1) begin
        accepted = 1'b1;
        if (track) push_expect(vd, off, mask, data, last, idx);
      end
      @(posedge clock); #1;
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL send_timeout: ready=%b after 10 cycles, required 1", req_ready);
      req_valid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] v);
    mem[a] = v;
    shadow[a] = v;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    @(negedge clock);
    checks++;
    if ({rf_ren, rf_wen, lc_valid} !== 3'b000) begin
      errors++; $display("FAIL reset_strobes: ren/wen/last=%b, required 000", {rf_ren, rf_wen, lc_valid});
    end
    checks++;
    if (inflight !== 8'h00) begin
      errors++; $display("FAIL reset_inflight: got %h, required 00", inflight);
    end
    checks++;
    if (rf_raddr !== 10'h0 || rf_waddr !== 10'h0 || rf_wdata !== 32'h0 || lc_index !== 3'h0) begin
      errors++; $display("FAIL reset_data: raddr=%h waddr=%h wdata=%h idx=%h, required all 0",
                         rf_raddr, rf_waddr, rf_wdata, lc_index);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b, required 1", req_ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full_mask();
    send_one(5'd3, 5'd7, 4'hF, 32'hDEADBEEF, 1'b0, 3'd0, 1'b1);
    req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rf_ren !== 1'b0) begin
      errors++; $display("FAIL full_no_read: rf_ren=%b, required 0", rf_ren);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 10'h067 || rf_wdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL full_write: wen=%b addr=%h data=%h, required 1 067 deadbeef",
                         rf_wen, rf_waddr, rf_wdata);
    end
    @(posedge clock); #1;
    idle(2);
  endtask

  task automatic test_partial();
    preload({5'd1, 5'd2}, 32'h11223344);
    send_one(5'd1, 5'd2, 4'h5, 32'hAABBCCDD, 1'b0, 3'd1, 1'b1);
    req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (rf_ren !== 1'b1 || rf_raddr !== 10'h022) begin
      errors++; $display("FAIL partial_read: ren=%b raddr=%h, required 1 022", rf_ren, rf_raddr);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (rf_wen !== 1'b1 || rf_waddr !== 10'h022 || rf_wdata !== 32'h11BB33DD) begin
      errors++; $display("FAIL partial_merge: wen=%b addr=%h data=%h, required 1 022 11bb33dd",
                         rf_wen, rf_waddr, rf_wdata);
    end
    @(posedge clock); #1;
    idle(2);
  endtask

  task automatic test_back_to_back();
    int          lows = 0;
    int          exp_lows;
    logic [31:0] last_wd = 32'h0;
`ifdef VRF_WRITE_FORWARD_EN
    exp_lows = 0;
`else
    exp_lows = 1;
`endif
    preload({5'd2, 5'd4}, 32'h0);
    send_one(5'd2, 5'd4, 4'h1, 32'h000000AA, 1'b0, 3'd3, 1'b1);
    send_one(5'd2, 5'd4, 4'h2, 32'h0000BB00, 1'b0, 3'd3, 1'b1);
    req_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (req_ready !== 1'b1) lows++;
      if (rf_wen === 1'b1 && rf_waddr == {5'd2, 5'd4}) last_wd = rf_wdata;
      @(posedge clock); #1;
    end
    checks++;
    if (lows != exp_lows) begin
      errors++; $display("FAIL b2b_ready_bubbles: got %0d, required %0d", lows, exp_lows);
    end
    checks++;
    if (last_wd !== 32'h0000BBAA) begin
      errors++; $display("FAIL b2b_final_word: got %h, required 0000bbaa", last_wd);
    end
  endtask

  task automatic test_zero_mask();
    send_one(5'd5, 5'd1, 4'h0, 32'h12345678, 1'b1, 3'd5, 1'b1);
    req_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (inflight[5] !== 1'b1) begin
      errors++; $display("FAIL zero_inflight_set: got %b, required 1", inflight[5]);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (rf_wen !== 1'b0 || lc_valid !== 1'b1 || lc_index !== 3'd5) begin
      errors++; $display("FAIL zero_commit: wen=%b last=%b idx=%0d, required 0 1 5", rf_wen, lc_valid, lc_index);
    end
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (inflight[5] !== 1'b0 || lc_valid !== 1'b0) begin
      errors++; $display("FAIL zero_after: inflight5=%b last=%b, required 0 0", inflight[5], lc_valid);
    end
    @(posedge clock); #1;
    idle(1);
  endtask

  task automatic test_streaming();
    int   pulses = 0;
    logic exp_if;
    for (int c = 0; c < 10; c++) begin
      if (c < 4) set_req(5'd7, 5'(c + 8), (c % 2 == 0) ? 4'hF : 4'h3, $urandom, c == 3, 3'd2);
      else req_valid = 1'b0;
      @(negedge clock);
      if (c < 4) begin
        checks++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL stream_ready c=%0d: got %b, required 1", c, req_ready);
        end else begin
          push_expect(req_vd, req_offset, req_mask, req_data, req_last, req_idx);
        end
      end
      exp_if = (c >= 1 && c <= 5);
      checks++;
      if (inflight[2] !== exp_if) begin
        errors++; $display("FAIL stream_inflight c=%0d: got %b, required %b", c, inflight[2], exp_if);
      end
      if (lc_valid === 1'b1) pulses++;
      @(posedge clock); #1;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL stream_last_pulses: got %0d, required 1", pulses);
    end
  endtask

  task automatic test_reset_midflight();
    send_one(5'd9, 5'd1, 4'hF, 32'hCAFEF00D, 1'b0, 3'd6, 1'b0);
    send_one(5'd9, 5'd2, 4'h3, 32'h55667788, 1'b0, 3'd6, 1'b0);
    req_valid = 1'b0;
    reset_n = 1'b0;
    @(negedge clock);
    checks++;
    if (inflight[6] !== 1'b1) begin
      errors++; $display("FAIL midrst_before: inflight6=%b, required 1", inflight[6]);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    checks++;
    if (req_ready !== 1'b1 || inflight !== 8'h00 || rf_wen !== 1'b0) begin
      errors++; $display("FAIL midrst_after: ready=%b inflight=%h wen=%b, required 1 00 0",
                         req_ready, inflight, rf_wen);
    end
    @(posedge clock); #1;
    idle(4);
    checks++;
    if (mem[{5'd9, 5'd1}] !== shadow[{5'd9, 5'd1}] || mem[{5'd9, 5'd2}] !== shadow[{5'd9, 5'd2}]) begin
      errors++; $display("FAIL midrst_sram: rows=%h %h, required %h %h", mem[{5'd9, 5'd1}],
                         mem[{5'd9, 5'd2}], shadow[{5'd9, 5'd1}], shadow[{5'd9, 5'd2}]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      shadow[i] = 32'h0;
    end
    rdata_q = 32'h0;
    reset_n = 1'b0;
    req_valid = 1'b0;
    req_vd = '0; req_offset = '0; req_mask = '0;
    req_data = '0; req_last = 1'b0; req_idx = '0;
    @(posedge clock); #1;
    test_reset();
    test_full_mask();
    test_partial();
    test_back_to_back();
    test_zero_mask();
    test_streaming();
    idle(3);
    test_reset_midflight();
    checks++;
    if (exp_wr_q.size() != 0 || exp_last_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: writes=%0d lasts=%0d left, required 0 0",
                         exp_wr_q.size(), exp_last_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
